// File: rtl/regfile_wordline_ctrl.sv
// Register-file port controller: registered one-hot read/write wordlines, pending-destination
// scoreboard, RAW hazard and write->read bypass flags. Optional macro: ZERO_REG_EN.
module regfile_wordline_ctrl #(
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_RD-1:0]                rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0]         rd_addr_i,
  input  logic                             wr_en_i,
  input  logic [ADDR_W-1:0]                wr_addr_i,
  input  logic                             iss_valid_i,
  input  logic                             iss_dst_en_i,
  input  logic [ADDR_W-1:0]                iss_dst_i,
  output logic [NUM_RD*(2**ADDR_W)-1:0]    rd_wl_o,
  output logic [(2**ADDR_W)-1:0]           wr_wl_o,
  output logic [NUM_RD-1:0]                rd_byp_o,
  output logic [NUM_RD-1:0]                rd_haz_o,
  output logic [ADDR_W:0]                  pend_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;

`ifdef ZERO_REG_EN
  localparam logic ZeroReg = 1'b1;
`else
  localparam logic ZeroReg = 1'b0;
`endif

  logic [DEPTH-1:0]        pend_q, pend_d;
  logic [NUM_RD*DEPTH-1:0] rd_wl_q, rd_wl_d;
  logic [DEPTH-1:0]        wr_wl_q, wr_wl_d;
  logic [NUM_RD-1:0]       byp_q, byp_d;
  logic [NUM_RD-1:0]       haz_q, haz_d;
  logic [ADDR_W:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]       rd_addr_p;
  logic                    hit_p;

  // Scoreboard: a new issue wins over a same-cycle writeback to the same entry.
  always_comb begin
    pend_d  = pend_q;
    wr_wl_d = '0;
    cnt_d   = '0;
    if (wr_en_i && !(ZeroReg && wr_addr_i == '0)) begin
      wr_wl_d[wr_addr_i] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_valid_i && iss_dst_en_i && iss_dst_i == ADDR_W'(i) && !(ZeroReg && i == 0)) begin
        pend_d[i] = 1'b1;
      end else if (wr_en_i && wr_addr_i == ADDR_W'(i)) begin
        pend_d[i] = 1'b0;
      end
      cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
    end
  end

  // Hazards look at pend_q, so an issue this cycle is only seen by next cycle's reads.
  always_comb begin
    rd_wl_d   = '0;
    byp_d     = '0;
    haz_d     = '0;
    rd_addr_p = '0;
    hit_p     = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr_p = rd_addr_i[p*ADDR_W +: ADDR_W];
      hit_p     = rd_en_i[p] && wr_en_i && (rd_addr_p == wr_addr_i)
                  && !(ZeroReg && rd_addr_p == '0);
      if (rd_en_i[p]) begin
        rd_wl_d[p*DEPTH + int'(rd_addr_p)] = 1'b1;
      end
      byp_d[p] = hit_p;
      haz_d[p] = rd_en_i[p] && pend_q[rd_addr_p] && !hit_p
                 && !(ZeroReg && rd_addr_p == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      rd_wl_q <= '0;
      wr_wl_q <= '0;
      byp_q   <= '0;
      haz_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      rd_wl_q <= rd_wl_d;
      wr_wl_q <= wr_wl_d;
      byp_q   <= byp_d;
      haz_q   <= haz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rd_wl_o    = rd_wl_q;
  assign wr_wl_o    = wr_wl_q;
  assign rd_byp_o   = byp_q;
  assign rd_haz_o   = haz_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: tb/tb_regfile_wordline_ctrl.sv
// Randomized bench for regfile_wordline_ctrl against a behavioural scoreboard model
// (honours ZERO_REG_EN when the macro is defined for both bench and design).
module tb_regfile_wordline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic        iss_valid;
  logic        iss_dst_en;
  logic [3:0]  iss_dst;
  logic [31:0] rd_wl;
  logic [15:0] wr_wl;
  logic [1:0]  rd_byp;
  logic [1:0]  rd_haz;
  logic [4:0]  pend_cnt;

`ifdef ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference state: the set of pending registers, plus expected outputs for the next edge.
  bit [15:0]   modelPend;
  logic [31:0] expRdWl;
  logic [15:0] expWrWl;
  logic [1:0]  expByp;
  logic [1:0]  expHaz;
  logic [4:0]  expCnt;

  regfile_wordline_ctrl #(.ADDR_W(4), .NUM_RD(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_en_i      (rd_en),
    .rd_addr_i    (rd_addr),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .iss_valid_i  (iss_valid),
    .iss_dst_en_i (iss_dst_en),
    .iss_dst_i    (iss_dst),
    .rd_wl_o      (rd_wl),
    .wr_wl_o      (wr_wl),
    .rd_byp_o     (rd_byp),
    .rd_haz_o     (rd_haz),
    .pend_cnt_o   (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, predicts the registered outputs, then checks them after the edge.
  task automatic applyStimulus(input logic r, input logic [1:0] re, input logic [3:0] a0,
                               input logic [3:0] a1, input logic we, input logic [3:0] wa,
                               input logic iv, input logic ide, input logic [3:0] id);
    logic [3:0] a;
    bit         fwd;
    @(negedge clk);
    rst = r; rd_en = re; rd_addr = {a1, a0}; wr_en = we; wr_addr = wa;
    iss_valid = iv; iss_dst_en = ide; iss_dst = id;
    expRdWl = '0; expWrWl = '0; expByp = '0; expHaz = '0;
    if (r) begin
      modelPend = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        a = (p == 0) ? a0 : a1;
        if (re[p]) expRdWl[p*16 +: 16] = 16'(1 << a);
        fwd = re[p] && we && (a == wa) && !(ZeroReg && a == 0);
        expByp[p] = fwd;
        expHaz[p] = re[p] && modelPend[a] && !fwd && !(ZeroReg && a == 0);
      end
      if (we && !(ZeroReg && wa == 0)) expWrWl = 16'(1 << wa);
      if (we) modelPend[wa] = 1'b0;
      if (iv && ide && !(ZeroReg && id == 0)) modelPend[id] = 1'b1;
    end
    expCnt = 5'($countones(modelPend));
    @(posedge clk);
    #1;
    checkOutput("rd_wl", 64'(rd_wl), 64'(expRdWl));
    checkOutput("wr_wl", 64'(wr_wl), 64'(expWrWl));
    checkOutput("rd_byp", 64'(rd_byp), 64'(expByp));
    checkOutput("rd_haz", 64'(rd_haz), 64'(expHaz));
    checkOutput("pend_cnt", 64'(pend_cnt), 64'(expCnt));
  endtask

  initial begin
    modelPend = '0;
    rst = 1'b1; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
    iss_valid = 1'b0; iss_dst_en = 1'b0; iss_dst = '0;

    // Reset with every request active
    applyStimulus(1, 2'b11, 4'h3, 4'h7, 1, 4'h3, 1, 1, 4'h5);
    checkOutput("reset_cnt", 64'(pend_cnt), 64'd0);

    applyStimulus(0, 2'b01, 4'hA, 4'h0, 0, 4'h0, 0, 0, 4'h0);
    checkOutput("rdwl_A_p0", 64'(rd_wl[15:0]), 64'h0400);
    checkOutput("rdwl_A_p1", 64'(rd_wl[31:16]), 64'h0000);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 2'b11, 4'(i), 4'(15 - i), 0, 4'h0, 0, 0, 4'h0);
      checkOutput("sweep_p0", 64'(rd_wl[15:0]), 64'(17'h1 << i));
      checkOutput("sweep_p1", 64'(rd_wl[31:16]), 64'(17'h1 << (15 - i)));
    end

    // Issue to r3, read it back (hazard), then write it alongside the read (bypass)
    applyStimulus(0, 2'b00, 4'h0, 4'h0, 0, 4'h0, 1, 1, 4'h3);
    applyStimulus(0, 2'b01, 4'h3, 4'h0, 0, 4'h0, 0, 0, 4'h0);
    checkOutput("haz_r3", 64'(rd_haz[0]), 64'd1);
    checkOutput("cnt_r3", 64'(pend_cnt), 64'd1);
    applyStimulus(0, 2'b01, 4'h3, 4'h0, 1, 4'h3, 0, 0, 4'h0);
    checkOutput("byp_r3", 64'(rd_byp[0]), 64'd1);
    checkOutput("haz_r3_resolved", 64'(rd_haz[0]), 64'd0);
    checkOutput("cnt_after_wb", 64'(pend_cnt), 64'd0);

    // Simultaneous issue and writeback to r5: the issue wins
    applyStimulus(0, 2'b00, 4'h0, 4'h0, 1, 4'h5, 1, 1, 4'h5);
    checkOutput("cnt_r5", 64'(pend_cnt), 64'd1);
    applyStimulus(0, 2'b10, 4'h0, 4'h5, 0, 4'h0, 0, 0, 4'h0);
    checkOutput("haz_r5", 64'(rd_haz[1]), 64'd1);

    // Register 0 handling (zeroed outputs only when ZERO_REG_EN is defined)
    applyStimulus(0, 2'b00, 4'h0, 4'h0, 1, 4'h9, 1, 1, 4'h0);
    applyStimulus(0, 2'b01, 4'h0, 4'h0, 1, 4'h0, 0, 0, 4'h0);
    checkOutput("zero_rdwl", 64'(rd_wl[15:0]), 64'h0001);

    // Random traffic with occasional mid-operation resets
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0), 2'($urandom), 4'($urandom), 4'($urandom),
                    ($urandom_range(0, 2) == 0), 4'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) != 0), 4'($urandom));
      checkOutput("onehot_p0", 64'($countones(rd_wl[15:0]) <= 1), 64'd1);
      checkOutput("onehot_p1", 64'($countones(rd_wl[31:16]) <= 1), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
